ssd_bcd_converter: RTL



---
 rtl/ssd_pkg.sv | 17 +
 rtl/bcd_nibble_adj.sv | 15 +
 rtl/ssd_bcd_converter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment BCD conversion path.
//   BIN_W_DEF / DIGITS_DEF : default binary width and BCD digit count
//   state_t                : converter control states
//   BCD_ADJ_THRESH/ADD     : double-dabble nibble correction constants
package ssd_pkg;

  localparam int unsigned BIN_W_DEF      = 13;
  localparam int unsigned DIGITS_DEF     = 4;
  localparam int unsigned BCD_ADJ_THRESH = 5;
  localparam int unsigned BCD_ADJ_ADD    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage : ssd_pkg

// File: rtl/bcd_nibble_adj.sv
// Double-dabble digit correction: adds 3 to any nibble of 5 or more so the
// following left shift carries correctly into the next decimal digit.
//   nibbleIn  : current BCD scratch digit
//   nibbleOut : corrected digit (4-bit wrap, never reached for legal inputs)
module bcd_nibble_adj
  import ssd_pkg::*;
(
  input  logic [3:0] nibbleIn,
  output logic [3:0] nibbleOut
);

  assign nibbleOut = (nibbleIn >= 4'(BCD_ADJ_THRESH)) ? nibbleIn + 4'(BCD_ADJ_ADD)
                                                     : nibbleIn;

endmodule : bcd_nibble_adj

// File: rtl/ssd_bcd_converter.sv
// Iterative binary-to-BCD converter (one double-dabble shift per clock)
// feeding the four-digit seven-segment driver. bcd_out holds the previous
// result until a conversion completes, so the display never sees partial
// digits.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   start   : single-cycle convert request, ignored while busy
//   bin_in  : binary value, sampled on the accepted start edge
//   busy    : conversion in progress
//   done    : one-cycle pulse when bcd_out is updated
//   bcd_out : packed BCD, digit 0 in [3:0]
// Build option: define SSD_BCD_AUTO_CONVERT_EN to start a conversion
// automatically whenever bin_in differs from the last converted value.
module ssd_bcd_converter
  import ssd_pkg::*;
#(
  parameter int unsigned BIN_W  = BIN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned SCR_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_t             state;
  state_t             stateNext;
  logic [BIN_W-1:0]   shiftReg;
  logic [BIN_W-1:0]   shiftNext;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   scratchNext;
  logic [SCR_W-1:0]   scratchAdj;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   countNext;
  logic               busyNext;
  logic               doneNext;
  logic [SCR_W-1:0]   bcdNext;
  logic               startEff;

  // Per-digit correction applied before every shift
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_nibble_adj uAdj (
      .nibbleIn  (scratch[4*d +: 4]),
      .nibbleOut (scratchAdj[4*d +: 4])
    );
  end

`ifdef SSD_BCD_AUTO_CONVERT_EN
  logic [BIN_W-1:0] lastBin;
  logic             autoStart;

  // A new value on bin_in requests a conversion on its own
  assign autoStart = (state == IDLE) && (bin_in != lastBin);
  assign startEff  = start | autoStart;

  // Remember the value handed to the converter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastBin <= '0;
    end else if (state == IDLE && startEff) begin
      lastBin <= bin_in;
    end
  end
`else
  assign startEff = start;
`endif

  // Next-state and datapath control
  always_comb begin
    stateNext   = state;
    shiftNext   = shiftReg;
    scratchNext = scratch;
    countNext   = count;
    busyNext    = busy;
    doneNext    = 1'b0;
    bcdNext     = bcd_out;
    unique case (state)
      IDLE: begin
        if (startEff) begin
          shiftNext   = bin_in;
          scratchNext = '0;
          countNext   = CNT_W'(BIN_W);
          busyNext    = 1'b1;
          stateNext   = SHIFT;
        end
      end
      SHIFT: begin
        // Adjusted scratch and shift register move left as one word;
        // the top scratch bit falls off
        scratchNext = {scratchAdj[SCR_W-2:0], shiftReg[BIN_W-1]};
        shiftNext   = {shiftReg[BIN_W-2:0], 1'b0};
        countNext   = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          bcdNext   = scratchNext;
          doneNext  = 1'b1;
          busyNext  = 1'b0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shiftReg <= '0;
      scratch  <= '0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      scratch  <= scratchNext;
      count    <= countNext;
      busy     <= busyNext;
      done     <= doneNext;
      bcd_out  <= bcdNext;
    end
  end

endmodule : ssd_bcd_converter
